// File: rtl/fpga_state_transmitter.sv
// Assembles the local game-state frame and shifts it MSB first to the opponent board,
// while forwarding each new location straight to the local renderer.
module fpga_state_transmitter #(
  parameter int DATA_WIDTH = 89,
  parameter int LOC_WIDTH  = 63,
  parameter int CLK_DIV    = 50
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] old_player_data_in,
  input  logic                  player_scored_in,
  input  logic                  old_player_data_in_valid,
  input  logic [LOC_WIDTH-1:0]  location_in,
  input  logic                  location_in_valid,
  output logic                  data_out,
  output logic                  data_clk_out,
  output logic                  sel_out,
  output logic [LOC_WIDTH-1:0]  location_out,
  output logic                  location_out_valid
);

  localparam int STAT_W   = 3;
  localparam int TAIL_W   = DATA_WIDTH - LOC_WIDTH - STAT_W;
  localparam int BIT_TIME = 2 * CLK_DIV;
  localparam int CNT_W    = $clog2(BIT_TIME + 1);
  localparam int BIT_W    = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GUARD} state_t;

  state_t                     state_q, state_d;
  logic [STAT_W+TAIL_W-1:0]   rec_q;
  logic [LOC_WIDTH-1:0]       loc_q;
  logic                       pending_q;
  logic [DATA_WIDTH-1:0]      shreg_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [BIT_W-1:0]           bit_q;
  logic [DATA_WIDTH-1:0]      frame;
  logic                       set_pending;
  logic                       take;
  logic                       bit_end;
  logic                       rec_loc_unused;

  // The record's own location field is superseded by the bounding-box location.
  assign rec_loc_unused = ^old_player_data_in[DATA_WIDTH-STAT_W-1:TAIL_W];

  assign frame       = {rec_q[STAT_W+TAIL_W-1 -: STAT_W], loc_q, rec_q[TAIL_W-1:0]};
  assign set_pending = location_in_valid | (old_player_data_in_valid & player_scored_in);
  assign take        = (state_q == IDLE) & pending_q;
  assign bit_end     = (cnt_q == CNT_W'(BIT_TIME - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bit_end && bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = GUARD;
      GUARD:   if (cnt_q == CNT_W'(CLK_DIV - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q            <= IDLE;
      pending_q          <= 1'b0;
      rec_q              <= '0;
      loc_q              <= '0;
      location_out       <= '0;
      location_out_valid <= 1'b0;
      shreg_q            <= '0;
      cnt_q              <= '0;
      bit_q              <= '0;
    end else begin
      state_q            <= state_d;
      location_out_valid <= location_in_valid;
      pending_q          <= set_pending | (pending_q & ~take);
      if (location_in_valid) begin
        loc_q        <= location_in;
        location_out <= location_in;
      end
      if (old_player_data_in_valid)
        rec_q <= {old_player_data_in[DATA_WIDTH-1 -: STAT_W], old_player_data_in[TAIL_W-1:0]};
      case (state_q)
        IDLE: begin
          // Frame is snapshotted here so later strobes never disturb it.
          if (pending_q) begin
            shreg_q <= frame;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        LOAD: cnt_q <= '0;
        SHIFT: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q != BIT_W'(DATA_WIDTH - 1)) begin
              bit_q   <= bit_q + BIT_W'(1);
              shreg_q <= shreg_q << 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GUARD: cnt_q <= cnt_q + CNT_W'(1);
        default: cnt_q <= '0;
      endcase
    end
  end

  assign sel_out      = ~((state_q == LOAD) || (state_q == SHIFT));
  assign data_out     = ~sel_out & shreg_q[DATA_WIDTH-1];
  assign data_clk_out = (state_q == SHIFT) && (cnt_q >= CNT_W'(CLK_DIV));

endmodule

// File: tb/tb_fpga_state_transmitter.sv
// Directed bench for fpga_state_transmitter: serial frame capture, location forwarding,
// busy-time strobes and mid-frame reset.
module tb_fpga_state_transmitter;
  localparam int DW = 89;
  localparam int LW = 63;
  localparam int CD = 50;
  localparam int FRAME_CYC = 1 + DW * 2 * CD;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] old_player_data_in;
  logic          player_scored_in;
  logic          old_player_data_in_valid;
  logic [LW-1:0] location_in;
  logic          location_in_valid;
  logic          data_out, data_clk_out, sel_out;
  logic [LW-1:0] location_out;
  logic          location_out_valid;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fpga_state_transmitter #(.DATA_WIDTH(DW), .LOC_WIDTH(LW), .CLK_DIV(CD)) dut (
    .clk_pixel_in(clk), .rst_in(rst),
    .old_player_data_in(old_player_data_in), .player_scored_in(player_scored_in),
    .old_player_data_in_valid(old_player_data_in_valid),
    .location_in(location_in), .location_in_valid(location_in_valid),
    .data_out(data_out), .data_clk_out(data_clk_out), .sel_out(sel_out),
    .location_out(location_out), .location_out_valid(location_out_valid)
  );

  typedef struct {
    logic [LW-1:0] loc;
    int            gap;
    logic [LW-1:0] exp_loc;
    logic          exp_vld;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic capture(output logic [DW-1:0] bits, output int nbits,
                         output int low_cyc, output int wait_cyc);
    logic prev;
    bits = '0; nbits = 0; low_cyc = 0; wait_cyc = 0; prev = 1'b0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (sel_out && wait_cyc < 20000);
    while (!sel_out && low_cyc < 20000) begin
      low_cyc++;
      if (data_clk_out && !prev) begin
        bits = {bits[DW-2:0], data_out};
        nbits++;
      end
      prev = data_clk_out;
      @(negedge clk);
    end
  endtask

  task automatic watch_idle(input int n, output int lows, output int vlds);
    lows = 0; vlds = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!sel_out) lows++;
      if (location_out_valid) vlds++;
    end
  endtask

  task automatic strobe_loc(input string name, input logic [LW-1:0] loc,
                            input logic [LW-1:0] exp_loc, input logic exp_vld);
    @(negedge clk);
    location_in = loc;
    location_in_valid = 1'b1;
    @(negedge clk);
    location_in_valid = 1'b0;
    check({name, "_loc_out"}, DW'(location_out), DW'(exp_loc));
    check({name, "_loc_vld"}, DW'(location_out_valid), DW'(exp_vld));
    @(negedge clk);
    check({name, "_vld_drop"}, DW'(location_out_valid), DW'(0));
    check({name, "_sel_low"}, DW'(sel_out), DW'(0));
  endtask

  task automatic strobe_rec(input logic [DW-1:0] rec, input logic scored);
    @(negedge clk);
    old_player_data_in = rec;
    player_scored_in = scored;
    old_player_data_in_valid = 1'b1;
    @(negedge clk);
    old_player_data_in_valid = 1'b0;
    player_scored_in = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [DW-1:0] bits, input int nbits,
                             input int low_cyc, input logic [DW-1:0] exp);
    check({name, "_nbits"}, DW'(nbits), DW'(DW));
    check({name, "_bits"}, bits, exp);
    check({name, "_len"}, DW'(low_cyc), DW'(FRAME_CYC));
  endtask

  initial begin
    logic [LW-1:0] loc1, loc_a, loc_last;
    logic [DW-1:0] rec1, rec2, bits_a, bits_b;
    int nb_a, nb_b, low_a, low_b, w_a, w_b, lows, vlds;
    vec_t vecs[4];

    loc1     = {11'b10010100001, 10'b1110101010, 11'b00110011001,
                10'b0101010101, 11'b11100011100, 10'b0000111111};
    loc_a    = {11'b00000110001, 10'b1000000001, 11'b01010101010,
                10'b1111000011, 11'b00011110000, 10'b1010101011};
    loc_last = {11'b11111101111, 10'b0010011100, 11'b10000000001,
                10'b0110110110, 11'b01111111110, 10'b1100110011};
    rec1 = {3'b101, 63'h7FFF_FFFF_FFFF_FFFF, 23'h5A5A5A};
    rec2 = {3'b111, 63'h1234_5678_9ABC_DEF0, 23'h3C0F1E};

    vecs[0] = '{loc: 63'h0123_4567_89AB_CDEF, gap: 200, exp_loc: 63'h0123_4567_89AB_CDEF, exp_vld: 1'b1};
    vecs[1] = '{loc: 63'h7FFF_0000_FFFF_0000, gap: 350, exp_loc: 63'h7FFF_0000_FFFF_0000, exp_vld: 1'b1};
    vecs[2] = '{loc: 63'h0000_0000_0000_0001, gap: 120, exp_loc: 63'h0000_0000_0000_0001, exp_vld: 1'b1};
    vecs[3] = '{loc: loc_last,                gap: 10,  exp_loc: loc_last,                exp_vld: 1'b1};

    rst = 1'b1;
    old_player_data_in = '0; player_scored_in = 1'b0; old_player_data_in_valid = 1'b0;
    location_in = '0; location_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sel", DW'(sel_out), DW'(1));
    check("rst_dclk", DW'(data_clk_out), DW'(0));
    check("rst_data", DW'(data_out), DW'(0));
    check("rst_vld", DW'(location_out_valid), DW'(0));
    check("rst_loc", DW'(location_out), DW'(0));

    // Unscored record: storage only.
    strobe_rec(rec1, 1'b0);
    watch_idle(300, lows, vlds);
    check("rec_only_no_frame", DW'(lows), DW'(0));
    check("rec_only_no_vld", DW'(vlds), DW'(0));

    // Location strobe launches a frame.
    fork
      capture(bits_a, nb_a, low_a, w_a);
      strobe_loc("loc1", loc1, loc1, 1'b1);
    join
    check_frame("frame1", bits_a, nb_a, low_a, {3'b101, loc1, rec1[22:0]});

    // Scored record reuses the previous location.
    watch_idle(100, lows, vlds);
    fork
      capture(bits_a, nb_a, low_a, w_a);
      strobe_rec(rec2, 1'b1);
    join
    check_frame("frame_scored", bits_a, nb_a, low_a, {3'b111, loc1, rec2[22:0]});

    // Strobes while busy: active frame untouched, one follow-up with the newest location.
    watch_idle(100, lows, vlds);
    fork
      begin
        capture(bits_a, nb_a, low_a, w_a);
        capture(bits_b, nb_b, low_b, w_b);
      end
      begin
        strobe_loc("loc_a", loc_a, loc_a, 1'b1);
        repeat (100) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          strobe_loc($sformatf("busy%0d", i), vecs[i].loc, vecs[i].exp_loc, vecs[i].exp_vld);
          repeat (vecs[i].gap) @(negedge clk);
        end
      end
    join
    check_frame("frame_busy", bits_a, nb_a, low_a, {3'b111, loc_a, rec2[22:0]});
    check_frame("frame_follow", bits_b, nb_b, low_b, {3'b111, loc_last, rec2[22:0]});
    total++;
    if (w_b >= CD && w_b <= CD + 2) passed++;
    else $display("FAIL guard_gap: got %0d cycles expected %0d..%0d", w_b, CD, CD + 2);
    watch_idle(500, lows, vlds);
    check("no_third_frame", DW'(lows), DW'(0));

    // Reset in the middle of a frame.
    strobe_loc("loc_rst", loc1, loc1, 1'b1);
    repeat (2000) @(negedge clk);
    check("pre_rst_busy", DW'(sel_out), DW'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_sel", DW'(sel_out), DW'(1));
    check("midrst_dclk", DW'(data_clk_out), DW'(0));
    check("midrst_data", DW'(data_out), DW'(0));
    check("midrst_loc", DW'(location_out), DW'(0));
    watch_idle(9500, lows, vlds);
    check("midrst_no_frame", DW'(lows), DW'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
